// File: rtl/seg7_reader.sv
// Seven-segment capture monitor: debounces the segment bus, decodes each newly
// stable pattern to a hex digit and queues it in a first-word-fall-through FIFO.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          clear,
  input  logic [6:0]                    segments,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    out_digit,
  output logic                          out_blank,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] digit;
  } entry_t;

  function automatic entry_t decode(input logic [6:0] pat);
    entry_t e;
    e = '0;
    case (pat)
      7'h3F: e.digit = 4'h0;
      7'h06: e.digit = 4'h1;
      7'h5B: e.digit = 4'h2;
      7'h4F: e.digit = 4'h3;
      7'h66: e.digit = 4'h4;
      7'h6D: e.digit = 4'h5;
      7'h7D: e.digit = 4'h6;
      7'h07: e.digit = 4'h7;
      7'h7F: e.digit = 4'h8;
      7'h6F: e.digit = 4'h9;
      7'h77: e.digit = 4'hA;
      7'h7C: e.digit = 4'hB;
      7'h39: e.digit = 4'hC;
      7'h5E: e.digit = 4'hD;
      7'h79: e.digit = 4'hE;
      7'h71: e.digit = 4'hF;
      7'h00: e.blank = 1'b1;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  logic [6:0]    samp_q, samp_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          acc_vld_q, acc_vld_d;
  logic [6:0]    acc_pat_q, acc_pat_d;
  logic [6:0]    last_acc_q, last_acc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, push_req, full, wr_en;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push_req  = acc_vld_q && (acc_pat_q != last_acc_q);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    samp_d     = samp_q;
    cnt_d      = cnt_q;
    acc_vld_d  = 1'b0;
    acc_pat_d  = acc_pat_q;
    last_acc_d = last_acc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    wr_en      = 1'b0;

    if (clear) begin
      cnt_d      = '0;
      last_acc_d = 7'h00;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Count saturates at STABLE so a held pattern fires exactly once.
      if (ena) begin
        samp_d = segments;
        if (cnt_q != '0 && segments == samp_q) begin
          if (cnt_q != STABLE) cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd1;
        end
        if (cnt_d == STABLE && cnt_q != STABLE) begin
          acc_vld_d = 1'b1;
          acc_pat_d = segments;
        end
      end else begin
        cnt_d = '0;
      end

      if (acc_vld_q) last_acc_d = acc_pat_q;

      push  = push_req && (!full || pop);
      wr_en = push;
      if (push_req && full && !pop) overflow_d = 1'b1;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q     <= 7'h00;
      cnt_q      <= '0;
      acc_vld_q  <= 1'b0;
      acc_pat_q  <= 7'h00;
      last_acc_q <= 7'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      samp_q     <= samp_d;
      cnt_q      <= cnt_d;
      acc_vld_q  <= acc_vld_d;
      acc_pat_q  <= acc_pat_d;
      last_acc_q <= last_acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is left unreset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= decode(acc_pat_q);
  end

  assign head       = mem[rd_ptr_q];
  assign out_digit  = out_valid ? head.digit : 4'h0;
  assign out_blank  = out_valid ? head.blank : 1'b0;
  assign out_err    = out_valid ? head.err   : 1'b0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: stimulus queues expected entries, a monitor
// compares each popped head against them; direct checks cover counts and flags.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic [6:0] segments;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_err;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];  // {err, blank, digit}

  seg7_reader #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .segments(segments),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_blank(out_blank), .out_err(out_err), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a head presented with out_ready high is consumed at the next edge.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got %0h, expected nothing",
                   {out_err, out_blank, out_digit});
        end else begin
          e = exp_q.pop_front();
          check("pop_entry", {26'd0, out_err, out_blank, out_digit}, {26'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    segments = pat;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && fifo_count != 0; i++) step();
    out_ready = 1'b0;
    check("drain_empty", {29'd0, fifo_count}, 32'd0);
    check("drain_scoreboard_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; segments = 7'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_digit", {28'd0, out_digit}, 32'd0);
    check("rst_blank", {31'd0, out_blank}, 32'd0);
    check("rst_err",   {31'd0, out_err},   32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    rst_n = 1'b1;
    hold(7'h00, 6);
    check("idle_blank_not_pushed", {29'd0, fifo_count}, 32'd0);

    // Basic capture: four samples, written on the following edge.
    exp_q.push_back(6'h03);
    hold(7'h4F, 4);
    check("basic_before_latency", {31'd0, out_valid}, 32'd0);
    hold(7'h4F, 1);
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_digit", {28'd0, out_digit}, 32'd3);
    check("basic_count", {29'd0, fifo_count}, 32'd1);

    // Filter: three-sample glitch is ignored.
    exp_q.push_back(6'h02);
    hold(7'h06, 3);
    hold(7'h5B, 5);
    check("filter_count", {29'd0, fifo_count}, 32'd2);
    drain();

    // Repeat, blank, error.
    exp_q.push_back(6'h05);
    exp_q.push_back(6'h10);
    exp_q.push_back(6'h20);
    hold(7'h6D, 10);
    hold(7'h00, 4);
    hold(7'h12, 5);
    check("rbe_count", {29'd0, fifo_count}, 32'd3);
    drain();

    // Overflow: fifth digit dropped.
    exp_q.push_back(6'h00);
    exp_q.push_back(6'h01);
    exp_q.push_back(6'h02);
    exp_q.push_back(6'h03);
    hold(7'h3F, 5);
    hold(7'h06, 5);
    hold(7'h5B, 5);
    hold(7'h4F, 5);
    hold(7'h66, 5);
    check("ovf_count", {29'd0, fifo_count}, 32'd4);
    check("ovf_flag",  {31'd0, overflow},   32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ovf_drain_rate", {29'd0, fifo_count}, 32'(3 - i));
    end
    out_ready = 1'b0;
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_ovf",   {31'd0, overflow},   32'd0);
    check("clear_count", {29'd0, fifo_count}, 32'd0);

    // Full FIFO with simultaneous push and pop.
    exp_q.push_back(6'h07);
    exp_q.push_back(6'h08);
    exp_q.push_back(6'h09);
    exp_q.push_back(6'h0A);
    exp_q.push_back(6'h0B);
    hold(7'h07, 5);
    hold(7'h7F, 5);
    hold(7'h6F, 5);
    hold(7'h77, 5);
    check("full_count", {29'd0, fifo_count}, 32'd4);
    hold(7'h7C, 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pushpop_count", {29'd0, fifo_count}, 32'd4);
    check("pushpop_ovf",   {31'd0, overflow},   32'd0);
    drain();

    // ena low pauses capture.
    ena = 1'b0;
    hold(7'h39, 8);
    check("ena_low_count", {29'd0, fifo_count}, 32'd0);
    ena = 1'b1;

    // Reset mid-run with two entries queued.
    exp_q.push_back(6'h0C);
    exp_q.push_back(6'h0E);
    hold(7'h39, 5);
    hold(7'h79, 5);
    check("pre_rst_count", {29'd0, fifo_count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_digit", {28'd0, out_digit}, 32'd0);
    check("async_rst_count", {29'd0, fifo_count}, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    hold(7'h00, 8);
    check("post_rst_blank_count", {29'd0, fifo_count}, 32'd0);
    check("post_rst_valid",       {31'd0, out_valid},  32'd0);
    check("final_scoreboard_left", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Capture-side monitor for the seven-segment output of a `tt_um_*` design: samples the 7-bit `segments` bus (`uo_out[6:0]`), waits for each pattern to hold stable, decodes it back to a hex digit, and queues each new value in a small FIFO drained by a valid/ready handshake. It is the reading end of the segment driver. It sits beside the user design, in the bench harness or as an on-chip self-check block, so displayed values can be logged without per-cycle polling.

## Interface
- `STABLE_CYCLES`, 4: consecutive sampling edges a pattern must hold before acceptance; legal range 2..15.
- `FIFO_DEPTH`, 4: entry count; power of two, 2..16.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low; one clock, `clk`.
- `ena`  in  1  sampling enable; low pauses capture, FIFO still drains.
- `clear`  in  1  synchronous flush of FIFO, flags and history.
- `segments`  in  7  segment bus; bit0=a … bit6=g; active high.
- `out_valid`  out  1  FIFO head holds an entry.
- `out_ready`  in  1  consumer accepts head when high with `out_valid`.
- `out_digit`  out  4  decoded hex value of the head entry.
- `out_blank`  out  1  head entry is the all-off pattern 0x00.
- `out_err`  out  1  head entry is an unrecognised pattern.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; an accepted pattern was dropped because the FIFO was full.

## Operation
- Decode table, 7-bit pattern to digit:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F
  - 0x00 → blank=1, digit=0.
  - Any other pattern → err=1, digit=0.
- Stability filter:
  - A pattern is accepted once it has been sampled on `STABLE_CYCLES` consecutive edges with `ena`=1.
  - Any change restarts the count.
  - After acceptance, further samples of the same pattern produce nothing.
- History:
  - `last_acc` (7 bits) records the last accepted pattern; its reset value is 0x00.
  - An accepted pattern equal to `last_acc` is not pushed. A different pattern is pushed, and `last_acc` updates even when the push is dropped.
- `ena`=0: the stability count resets to 0 and no acceptance occurs. `last_acc` is kept.
- FIFO:
  - First-word-fall-through: the head is visible on the `out_*` data outputs whenever `out_valid`=1.
  - While `out_valid`=0, `out_digit`/`out_blank`/`out_err` are driven 0.
- Pop occurs on any edge with `out_valid`&&`out_ready`.
- Full FIFO:
  - Push with no pop in the same cycle: the entry is dropped and `overflow`←1.
  - Push and pop in the same cycle: both occur and the count is unchanged.
- `clear`=1 on an edge:
  - FIFO emptied; `fifo_count`←0, `overflow`←0.
  - `last_acc`←0x00; stability count←0.
  - `clear` has priority over push and pop in the same cycle.

## Timing
- Reset: `out_valid`=0, `out_digit`=0, `out_blank`=0, `out_err`=0, `fifo_count`=0, `overflow`=0. Internal state: `last_acc`=0x00, stability count=0, FIFO pointers=0.
- Latency: pattern first sampled at edge N and held through edge N+STABLE_CYCLES−1 → written at edge N+STABLE_CYCLES. `out_valid` rises after that edge if the FIFO was empty.
- A pattern that changes before edge N+STABLE_CYCLES−1 is never accepted.
- Pop is visible on the next cycle: a new head appears, or `out_valid` falls.
- Back-to-back pops with `out_ready` held high drain one entry per cycle.
- `overflow` remains set until `clear` or reset.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.

## Test plan
- **Basic capture**: reset, `ena`=1, `out_ready`=0, drive 0x4F for 4 cycles.
  - `out_valid` rises at edge 4 with `out_digit`=3, `fifo_count`=1.
- **Filter**: drive 0x06 for 3 cycles, then 0x5B for 5 cycles.
  - Exactly one entry is pushed: digit 2. The 0x06 glitch is absent.
- **Repeat, blank, error**: drive 0x6D held 10 cycles, then 0x00 for 4, then 0x12 for 4.
  - Three entries: digit 5; blank=1; err=1.
- **Overflow**: `out_ready`=0, present 5 distinct valid digits.
  - `fifo_count`=4; `overflow`=1; the 5th digit is absent.
  - With `out_ready`=1, digits drain in order, one per cycle.
  - `clear` → `overflow`=0.
- **Full with simultaneous push and pop**: FIFO full, `out_ready`=1 on the cycle a new digit is accepted.
  - `fifo_count` stays 4; `overflow` stays 0; the new digit arrives last.
- **Reset mid-run**: assert `rst_n`=0 with 2 entries queued.
  - All outputs go to 0 immediately.
  - After release, 0x00 held stable pushes nothing.
